reaction_timer_ctrl: RTL

//  Top-level sequencer for the reaction-time monitor. Consumes the 1 ms strobe derived from the

---
 rtl/rt_pkg.sv | 27 ++
 rtl/rise_edge_det.sv | 22 ++
 rtl/reaction_timer_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rt_pkg.sv
// Shared definitions for the reaction-time monitor: state encoding, default limits and the
// random-source step function.
package rt_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StArm  = 3'd1,
        StGo   = 3'd2,
        StDone = 3'd3,
        StFoul = 3'd4,
        StTmo  = 3'd5
    } rt_state_e;

    localparam int unsigned DEF_MIN_DELAY_MS = 1000;
    localparam int unsigned DEF_RAND_BITS    = 11;
    localparam int unsigned DEF_MAX_TIME_MS  = 9999;
    localparam int unsigned TIME_W           = 14;
    localparam int unsigned LFSR_W           = 16;
    // Board clock is 50 MHz; the 1 ms strobe comes from an external divider of this period.
    localparam int unsigned TICK_PERIOD_CLKS = 50000;

    // 16-bit Fibonacci step, polynomial x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a debounced, already-synchronous level. The previous level resets
// high so a button held through reset does not fire on the first cycle.
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= d;
        end
    end

    assign pulse = d & ~prev_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time trial sequencer: random foreperiod, GO lamp, millisecond count until response,
// with false-start and timeout outcomes. All outputs are registered decodes of the state.
module reaction_timer_ctrl
    import rt_pkg::*;
#(
    parameter int unsigned MIN_DELAY_MS = DEF_MIN_DELAY_MS,
    parameter int unsigned RAND_BITS    = DEF_RAND_BITS,
    parameter int unsigned MAX_TIME_MS  = DEF_MAX_TIME_MS,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1ms,
    input  logic              start_btn,
    input  logic              react_btn,
    output logic              led_go,
    output logic [TIME_W-1:0] time_ms,
    output logic              result_valid,
    output logic              false_start,
    output logic              timeout,
    output logic              busy
);

    localparam int unsigned DELAY_MAX = MIN_DELAY_MS + (1 << RAND_BITS) - 1;
    localparam int unsigned DW        = $clog2(DELAY_MAX + 1);

    logic start_edge;
    logic react_edge;

    logic [LFSR_W-1:0] lfsr_q;
    logic [DW-1:0]     delay_cnt_q;
    logic [DW-1:0]     delay_load;
    logic [TIME_W-1:0] time_q;
    rt_state_e         state_q;

    logic led_go_q;
    logic result_valid_q;
    logic false_start_q;
    logic timeout_q;
    logic busy_q;

    rise_edge_det u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (start_btn),
        .pulse (start_edge)
    );

    rise_edge_det u_react_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (react_btn),
        .pulse (react_edge)
    );

    // Free-running so the sampled value depends on when the subject presses start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign delay_load = DW'(MIN_DELAY_MS) + DW'(lfsr_q[RAND_BITS-1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            delay_cnt_q    <= '0;
            time_q         <= '0;
            led_go_q       <= 1'b0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            led_go_q       <= (state_q == StGo);
            result_valid_q <= (state_q == StDone);
            false_start_q  <= (state_q == StFoul);
            timeout_q      <= (state_q == StTmo);
            busy_q         <= (state_q == StArm) || (state_q == StGo);

            // A start edge restarts the trial from any state and beats a same-cycle react.
            if (start_edge) begin
                state_q     <= StArm;
                delay_cnt_q <= delay_load;
                time_q      <= '0;
            end else begin
                unique case (state_q)
                    StArm: begin
                        if (react_edge) begin
                            state_q <= StFoul;
                        end else if (tick_1ms) begin
                            delay_cnt_q <= delay_cnt_q - DW'(1);
                            if (delay_cnt_q == DW'(1)) begin
                                state_q <= StGo;
                            end
                        end
                    end
                    StGo: begin
                        if (tick_1ms) begin
                            time_q <= time_q + TIME_W'(1);
                        end
                        if (react_edge) begin
                            state_q <= StDone;
                        end else if (tick_1ms && (time_q == TIME_W'(MAX_TIME_MS - 1))) begin
                            state_q <= StTmo;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign led_go       = led_go_q;
    assign time_ms      = time_q;
    assign result_valid = result_valid_q;
    assign false_start  = false_start_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

endmodule
